// File: rtl/bcd_ctrl_pkg.sv
// rtl/bcd_ctrl_pkg.sv - shared state encoding and constants for the BCD run/pause/clear counter
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // dp_ctrl: [3] tens blink, [2] tens static, [1] units blink, [0] units static
    localparam logic [3:0] DP_IDLE  = 4'b0000;
    localparam logic [3:0] DP_RUN   = 4'b0010;
    localparam logic [3:0] DP_PAUSE = 4'b0101;
    localparam logic [3:0] DP_DONE  = 4'b1010;

    localparam logic [7:0] BCD_MIN = 8'h00;
    localparam logic [7:0] BCD_MAX = 8'h99;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, stability counter and rising-edge pulse for a push-button
module btn_debounce #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // cnt counts consecutive samples disagreeing with the accepted level; any agreeing sample restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                pulse <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_count_ctrl.sv
// rtl/bcd_count_ctrl.sv - two-digit BCD up/down counter with run/pause/clear control and DP patterns
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 5000000,
    parameter int DEB_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       dir,
    output logic [7:0] num,
    output logic [3:0] dp_ctrl,
    output logic       running,
    output logic       done
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {(v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {(v[7:4] == 4'd0) ? 4'd9 : v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    logic          start_pulse;
    logic          clear_pulse;
    logic          dir_s1;
    logic          dir_s2;

    state_t        state;
    state_t        state_nx;
    logic [7:0]    num_nx;
    logic [7:0]    stepped;
    logic [7:0]    reload;
    logic [7:0]    terminal;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nx;
    logic          count_down;
    logic          count_down_nx;
    logic          tick;
    logic [3:0]    dp_nx;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_start),
        .pulse (start_pulse)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_clear),
        .pulse (clear_pulse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_s1 <= 1'b0;
            dir_s2 <= 1'b0;
        end else begin
            dir_s1 <= dir;
            dir_s2 <= dir_s1;
        end
    end

    always_comb begin
        state_nx      = state;
        num_nx        = num;
        presc_nx      = presc;
        count_down_nx = count_down;
        reload        = dir_s2 ? BCD_MAX : BCD_MIN;
        terminal      = count_down ? BCD_MIN : BCD_MAX;
        tick          = (state == RUN) && (presc == PRE_LAST);
        stepped       = count_down ? bcd_dec(num) : bcd_inc(num);

        if (en) begin
            if (clear_pulse) begin
                state_nx = IDLE;
                num_nx   = reload;
                presc_nx = '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        num_nx   = reload;
                        presc_nx = '0;
                        if (start_pulse) begin
                            state_nx      = RUN;
                            count_down_nx = dir_s2;
                        end
                    end
                    RUN: begin
                        presc_nx = tick ? '0 : presc + PW'(1);
                        if (tick)
                            num_nx = stepped;
                        // reaching the terminal value wins over a simultaneous pause so num never leaves 00..99
                        if (tick && stepped == terminal)
                            state_nx = DONE;
                        else if (start_pulse)
                            state_nx = PAUSE;
                    end
                    PAUSE: begin
                        if (start_pulse)
                            state_nx = RUN;
                    end
                    DONE: begin
                    end
                endcase
            end
        end

        unique case (state_nx)
            IDLE:  dp_nx = DP_IDLE;
            RUN:   dp_nx = DP_RUN;
            PAUSE: dp_nx = DP_PAUSE;
            DONE:  dp_nx = DP_DONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            num        <= BCD_MIN;
            presc      <= '0;
            count_down <= 1'b0;
            dp_ctrl    <= DP_IDLE;
            running    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            num        <= num_nx;
            presc      <= presc_nx;
            count_down <= count_down_nx;
            dp_ctrl    <= dp_nx;
            running    <= (state_nx == RUN);
            done       <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb/tb_bcd_count_ctrl.sv - scoreboard bench for bcd_count_ctrl against a decimal reference model
module tb_bcd_count_ctrl;

    localparam int TD  = 4;
    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] num;
    logic [3:0] dp_ctrl;
    logic       running;
    logic       done;

    bcd_count_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .dir       (dir),
        .num       (num),
        .dp_ctrl   (dp_ctrl),
        .running   (running),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] num;
        logic [3:0] dp;
        logic       running;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // reference model: count kept as a plain integer 0..99
    int m_state;
    int m_count;
    int m_phase;
    bit m_up;
    bit b_s1[3];
    bit b_s2[3];
    bit b_lvl[2];
    bit b_pulse[2];
    int b_run[2];

    bit cur_s = 0;
    bit cur_c = 0;
    bit cur_d = 0;
    bit cur_e = 1;

    function automatic exp_t model_out();
        exp_t e;
        e.num     = {4'(m_count / 10), 4'(m_count % 10)};
        case (m_state)
            1:       e.dp = 4'b0010;
            2:       e.dp = 4'b0101;
            3:       e.dp = 4'b1010;
            default: e.dp = 4'b0000;
        endcase
        e.running = (m_state == 1);
        e.done    = (m_state == 3);
        return e;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_count = 0;
        m_phase = 0;
        m_up    = 1;
        for (int i = 0; i < 3; i++) begin
            b_s1[i] = 0;
            b_s2[i] = 0;
        end
        for (int i = 0; i < 2; i++) begin
            b_lvl[i]   = 0;
            b_pulse[i] = 0;
            b_run[i]   = 0;
        end
    endtask

    task automatic model_edge();
        bit sp;
        bit cp;
        bit ds;
        bit tick;
        sp = b_pulse[0];
        cp = b_pulse[1];
        ds = b_s2[2];
        if (en) begin
            if (cp) begin
                m_state = 0;
                m_count = ds ? 99 : 0;
                m_phase = 0;
            end else begin
                case (m_state)
                    0: begin
                        m_count = ds ? 99 : 0;
                        m_phase = 0;
                        if (sp) begin
                            m_state = 1;
                            m_up    = !ds;
                        end
                    end
                    1: begin
                        tick    = (m_phase == TD - 1);
                        m_phase = (m_phase + 1) % TD;
                        if (tick)
                            m_count = m_up ? m_count + 1 : m_count - 1;
                        if (tick && m_count == (m_up ? 99 : 0))
                            m_state = 3;
                        else if (sp)
                            m_state = 2;
                    end
                    2: if (sp) m_state = 1;
                    default: ;
                endcase
            end
        end
        for (int i = 0; i < 2; i++) begin
            b_pulse[i] = 0;
            if (b_s2[i] == b_lvl[i]) begin
                b_run[i] = 0;
            end else begin
                b_run[i]++;
                if (b_run[i] == DEB) begin
                    b_lvl[i]   = b_s2[i];
                    b_pulse[i] = b_s2[i];
                    b_run[i]   = 0;
                end
            end
        end
        for (int i = 0; i < 3; i++) b_s2[i] = b_s1[i];
        b_s1[0] = btn_start;
        b_s1[1] = btn_clear;
        b_s1[2] = dir;
    endtask

    task automatic step(input bit r);
        @(negedge clk);
        #1;
        rst       = r;
        btn_start = cur_s;
        btn_clear = cur_c;
        dir       = cur_d;
        en        = cur_e;
        if (r) model_reset();
        else   model_edge();
        exp_q.push_back(model_out());
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step(0);
    endtask

    task automatic press_start(input int hold, input int gap);
        cur_s = 1; cyc(hold);
        cur_s = 0; cyc(gap);
    endtask

    task automatic press_clear(input int hold, input int gap);
        cur_c = 1; cyc(hold);
        cur_c = 0; cyc(gap);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            if ({num, dp_ctrl, running, done} !== mon_e) begin
                miscompares++;
                $display("FAIL output_check t=%0t got num=%h dp=%b run=%b done=%b required num=%h dp=%b run=%b done=%b",
                         $time, num, dp_ctrl, running, done, mon_e.num, mon_e.dp, mon_e.running, mon_e.done);
            end
        end
    end

    initial begin
        model_reset();
        step(1);
        step(1);
        cur_e = 1;
        cur_d = 0;
        cyc(3);

        // count up to completion, then a press in DONE must change nothing
        press_start(10, 2);
        cyc(420);
        press_start(8, 50);

        // count down from 99 to 00
        cur_d = 1;
        cyc(5);
        press_clear(6, 4);
        press_start(8, 4);
        cyc(420);
        cur_d = 0;
        press_clear(6, 6);

        // bounced start, then run, then asynchronous reset mid-count
        cur_s = 1; cyc(1);
        cur_s = 0; cyc(1);
        cur_s = 1; cyc(8);
        cur_s = 0; cyc(30);
        step(1);
        #2;
        vectors++;
        if ({num, dp_ctrl, running, done} !== 14'b0) begin
            miscompares++;
            $display("FAIL async_reset got num=%h dp=%b run=%b done=%b required all zero",
                     num, dp_ctrl, running, done);
        end
        step(1);
        cyc(3);

        // pause/resume, en freeze, simultaneous clear and start
        press_start(6, 10);
        press_start(6, 20);
        press_start(6, 7);
        cur_e = 0;
        press_start(6, 20);
        cur_e = 1;
        cyc(12);
        cur_s = 1; cur_c = 1; cyc(8);
        cur_s = 0; cur_c = 0; cyc(8);

        // randomized traffic
        for (int it = 0; it < 1500; it++) begin
            case ($urandom_range(0, 11))
                0, 1, 2, 3: press_start($urandom_range(1, 8), $urandom_range(1, 12));
                4:          if ($urandom_range(0, 3) == 0) press_clear($urandom_range(1, 6), $urandom_range(1, 6));
                5:          begin cur_d = ~cur_d; cyc($urandom_range(1, 4)); end
                6:          begin cur_e = 0; cyc($urandom_range(1, 10)); cur_e = 1; end
                7:          begin
                                cur_s = 1; cyc(1); cur_s = 0; cyc(1);
                                cur_s = 1; cyc($urandom_range(1, 6)); cur_s = 0; cyc(3);
                            end
                default:    cyc($urandom_range(1, 40));
            endcase
        end

        @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
